// File: rtl/long_mul_unit.sv
// ============================================================================
// Module   : long_mul_unit
// Brief    : 32x32->64 iterative shift-add multiplier (UMULL/SMULL) with
//            register-file writeback. Define LONG_MUL_ACCUM_EN for UMLAL/SMLAL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module long_mul_unit #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic [REG_AW-1:0] rdlo,
  input  logic [REG_AW-1:0] rdhi,
`ifdef LONG_MUL_ACCUM_EN
  input  logic              accumulate,
  input  logic [63:0]       acc_in,
`endif
  output logic              busy,
  output logic              done,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_lo_addr,
  output logic [REG_AW-1:0] wb_hi_addr,
  output logic [63:0]       wb_data,
  output logic              res_n,
  output logic              res_z,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [5:0]        r_cnt;
  logic [63:0]       r_mcand;
  logic [31:0]       r_mplier;
  logic [63:0]       r_prod;
  logic              r_neg;
  logic [REG_AW-1:0] r_lo;
  logic [REG_AW-1:0] r_hi;

  logic [31:0]       w_mag_a;
  logic [31:0]       w_mag_b;
  logic [63:0]       w_fix;
  logic              w_addr_bad;

  // Magnitude of -2^31 is 0x8000_0000, which still fits as unsigned.
  assign w_mag_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign w_mag_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

`ifdef LONG_MUL_ACCUM_EN
  logic [63:0] r_acc;
  assign w_fix = (r_neg ? (~r_prod + 64'd1) : r_prod) + r_acc;
`else
  assign w_fix = r_neg ? (~r_prod + 64'd1) : r_prod;
`endif

  // The PC (all-ones) and overlapping destinations cannot take a 64-bit write.
  assign w_addr_bad = (r_lo == r_hi) || (&r_lo) || (&r_hi);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_prod     <= '0;
      r_neg      <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
`ifdef LONG_MUL_ACCUM_EN
      r_acc      <= '0;
`endif
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_we      <= 1'b0;
      wb_lo_addr <= '0;
      wb_hi_addr <= '0;
      wb_data    <= '0;
      res_n      <= 1'b0;
      res_z      <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_mcand  <= {32'd0, w_mag_a};
            r_mplier <= w_mag_b;
            r_prod   <= '0;
            r_neg    <= is_signed & (op_a[31] ^ op_b[31]);
            r_lo     <= rdlo;
            r_hi     <= rdhi;
`ifdef LONG_MUL_ACCUM_EN
            r_acc    <= accumulate ? acc_in : 64'd0;
`endif
            busy     <= 1'b1;
          end
        end
        S_CALC: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state    <= S_DONE;
          r_prod     <= w_fix;
          wb_data    <= w_fix;
          res_n      <= w_fix[63];
          res_z      <= (w_fix == 64'd0);
          wb_lo_addr <= r_lo;
          wb_hi_addr <= r_hi;
          done       <= 1'b1;
          wb_we      <= ~w_addr_bad;
          addr_err   <= w_addr_bad;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          wb_we    <= 1'b0;
          addr_err <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_long_mul_unit.sv
// ============================================================================
// Module   : tb_long_mul_unit
// Brief    : Directed self-checking bench for long_mul_unit with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_long_mul_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  rdlo = '0;
  logic [3:0]  rdhi = '0;
`ifdef LONG_MUL_ACCUM_EN
  logic        accumulate = 1'b0;
  logic [63:0] acc_in = '0;
`endif
  logic        busy, done, wb_we, res_n, res_z, addr_err;
  logic [3:0]  wb_lo_addr, wb_hi_addr;
  logic [63:0] wb_data;

  long_mul_unit #(.REG_AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .rdlo(rdlo), .rdhi(rdhi),
`ifdef LONG_MUL_ACCUM_EN
    .accumulate(accumulate), .acc_in(acc_in),
`endif
    .busy(busy), .done(done), .wb_we(wb_we),
    .wb_lo_addr(wb_lo_addr), .wb_hi_addr(wb_hi_addr),
    .wb_data(wb_data), .res_n(res_n), .res_z(res_z), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op reports 34 cycles later; result is plain arithmetic.
  bit          m_busy = 0, m_done = 0, m_we = 0, m_err = 0, m_n = 0, m_z = 0;
  int          m_rem = 0;
  logic [63:0] m_data = '0, m_pend = '0;
  logic [3:0]  m_lo = '0, m_hi = '0;

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_rem = 0; m_done = 0; m_we = 0; m_err = 0;
      m_data = '0; m_n = 0; m_z = 0;
    end else if (m_busy) begin
      if (m_rem == 0) begin
        m_busy = 0; m_done = 0; m_we = 0; m_err = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1;
          m_data = m_pend;
          m_n    = m_pend[63];
          m_z    = (m_pend == 64'd0);
          m_err  = (m_lo == m_hi) || (m_lo == 4'hF) || (m_hi == 4'hF);
          m_we   = !m_err;
        end
      end
    end else if (start) begin
      m_busy = 1;
      m_rem  = 33;
      m_pend = ref_mul(is_signed, op_a, op_b);
`ifdef LONG_MUL_ACCUM_EN
      if (accumulate) m_pend = m_pend + acc_in;
`endif
      m_lo = rdlo;
      m_hi = rdhi;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("wb_we", 64'(wb_we), 64'(m_we));
      chk("addr_err", 64'(addr_err), 64'(m_err));
      chk("wb_data", wb_data, m_data);
      chk("res_n", 64'(res_n), 64'(m_n));
      chk("res_z", 64'(res_z), 64'(m_z));
      if (m_done) begin
        chk("wb_lo_addr", 64'(wb_lo_addr), 64'(m_lo));
        chk("wb_hi_addr", 64'(wb_hi_addr), 64'(m_hi));
      end
    end
  end

  // Issues one op, scrambles inputs after acceptance, optionally re-pulses
  // start at cycle pulse_at, and checks latency plus literal results.
  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] lo, input logic [3:0] hi,
                        input int pulse_at, input logic [63:0] exp_data,
                        input logic exp_we, input logic exp_n, input logic exp_z);
    int cnt = 0;
    @(negedge clk);
    is_signed = s; op_a = a; op_b = b; rdlo = lo; rdhi = hi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt = 1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; is_signed = ~s;
    rdlo = 4'($urandom); rdhi = 4'($urandom);
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
      start = (cnt == pulse_at);
    end
    start = 1'b0;
    chk({name, ".latency"}, 64'(cnt), 64'd34);
    chk({name, ".data"}, wb_data, exp_data);
    chk({name, ".we"}, 64'(wb_we), 64'(exp_we));
    chk({name, ".err"}, 64'(addr_err), 64'(!exp_we));
    chk({name, ".n"}, 64'(res_n), 64'(exp_n));
    chk({name, ".z"}, 64'(res_z), 64'(exp_z));
    repeat (2) @(negedge clk);
    chk({name, ".idle"}, 64'(busy), 64'd0);
  endtask

  int dones;
  always @(posedge clk) if (done) dones++;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.data", wb_data, 64'd0);
    check_en = 1'b1;

    run_op("umul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 4'd3, 0,
           64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1, 1'b0);
    run_op("smul_neg", 1'b1, 32'hFFFF_FFFD, 32'd7, 4'd1, 4'd4, 0,
           64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b1, 1'b0);
    run_op("smul_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 4'd6, 4'd7, 0,
           64'h4000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
    dones = 0;
    run_op("umul_zero", 1'b0, 32'd0, 32'h1234_5678, 4'd0, 4'd1, 10,
           64'd0, 1'b1, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    chk("zero.single_done", 64'(dones), 64'd1);
    run_op("same_dest", 1'b0, 32'd5, 32'd6, 4'd5, 4'd5, 0,
           64'd30, 1'b0, 1'b0, 1'b0);
    run_op("pc_dest", 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 4'd3, 4'd15, 0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);

    // Mid-operation reset: everything clears and the op never reports.
    @(negedge clk);
    is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9; rdlo = 4'd2; rdhi = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.data", wb_data, 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    dones = 0;
    repeat (50) @(negedge clk);
    chk("abort.no_done", 64'(dones), 64'd0);
    run_op("after_abort", 1'b0, 32'h0001_0000, 32'h0001_0000, 4'd8, 4'd9, 0,
           64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0);

    // Start held high across DONE: second op accepted only in the next IDLE.
    @(negedge clk);
    is_signed = 1'b1; op_a = 32'd100; op_b = 32'hFFFF_FFFF; rdlo = 4'd1; rdhi = 4'd2; start = 1'b1;
    repeat (80) @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("b2b.final_data", wb_data, 64'hFFFF_FFFF_FFFF_FF9C);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
